// File: rtl/pe_array_tile_sequencer_if.sv
// Host and datapath control bundle for the PE array tile sequencer.
// The sequencer takes the slave view; host/bench takes the master view.
interface pe_array_tile_sequencer_if #(
  parameter int nb_taps                = 11,
  parameter int width_current_tap      = 4,
  parameter int act_buff_addr_width    = 10,
  parameter int weight_buff_addr_width = 7,
  parameter int obf_addr_width         = 13
);
  logic                              start;
  logic                              stall;
  logic [3:0]                        cfg_n_ap;
  logic [act_buff_addr_width-1:0]    cfg_nb_act;
  logic [act_buff_addr_width-1:0]    cfg_act_base;
  logic [weight_buff_addr_width-1:0] cfg_w_base;
  logic [obf_addr_width-1:0]         cfg_obf_base;
  logic                              busy;
  logic                              done;
  logic                              weight_buff_rEn;
  logic [weight_buff_addr_width-1:0] weight_buff_rAddr;
  logic [nb_taps-1:0]                weight_load_en;
  logic                              act_buff_rEn;
  logic [act_buff_addr_width-1:0]    act_buff_rAddr;
  logic [2:0]                        PAMAC_BPEB_sel;
  logic                              PAMAC_DFF_en;
  logic                              PAMAC_first_cycle;
  logic [width_current_tap-1:0]      current_tap;
  logic                              out_reg_en;
  logic                              obf_wEn;
  logic [obf_addr_width-1:0]         obf_wAddr;

  modport master (
    output start, stall, cfg_n_ap, cfg_nb_act,
    output cfg_act_base, cfg_w_base, cfg_obf_base,
    input  busy, done,
    input  weight_buff_rEn, weight_buff_rAddr, weight_load_en,
    input  act_buff_rEn, act_buff_rAddr,
    input  PAMAC_BPEB_sel, PAMAC_DFF_en, PAMAC_first_cycle,
    input  current_tap, out_reg_en, obf_wEn, obf_wAddr
  );

  modport slave (
    input  start, stall, cfg_n_ap, cfg_nb_act,
    input  cfg_act_base, cfg_w_base, cfg_obf_base,
    output busy, done,
    output weight_buff_rEn, weight_buff_rAddr, weight_load_en,
    output act_buff_rEn, act_buff_rAddr,
    output PAMAC_BPEB_sel, PAMAC_DFF_en, PAMAC_first_cycle,
    output current_tap, out_reg_en, obf_wEn, obf_wAddr
  );
endinterface

// File: rtl/pe_array_tile_sequencer.sv
// Tile sequencer: weight load, then per activation read/compute/writeback.
// Outputs are registered decodes of the next state and counters.
module pe_array_tile_sequencer #(
  parameter int nb_taps                = 11,
  parameter int width_current_tap      = 4,
  parameter int act_buff_addr_width    = 10,
  parameter int weight_buff_addr_width = 7,
  parameter int obf_addr_width         = 13
) (
  input logic clk,
  input logic rst,
  pe_array_tile_sequencer_if.slave bus
);

  localparam int NB = nb_taps;
  localparam int TW = width_current_tap;
  localparam int AW = act_buff_addr_width;
  localparam int WW = weight_buff_addr_width;
  localparam int OW = obf_addr_width;
  localparam int KW = $clog2(nb_taps + 1);

  typedef enum logic [2:0] {
    IDLE, WLOAD, ACT_RD, COMPUTE, WB, DONE
  } state_e;

  state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [2:0]    b_q, b_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [3:0]    n_ap_q, n_ap_d;
  logic [AW-1:0] nb_act_q, nb_act_d;
  logic [AW-1:0] act_base_q, act_base_d;
  logic [WW-1:0] w_base_q, w_base_d;
  logic [OW-1:0] obf_base_q, obf_base_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          w_ren_q, w_ren_d;
  logic [WW-1:0] w_addr_q, w_addr_d;
  logic [NB-1:0] wl_en_q, wl_en_d;
  logic          a_ren_q, a_ren_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [2:0]    sel_q, sel_d;
  logic          dff_en_q, dff_en_d;
  logic          first_q, first_d;
  logic [TW-1:0] tap_out_q, tap_out_d;
  logic          oreg_q, oreg_d;
  logic          o_wen_q, o_wen_d;
  logic [OW-1:0] o_addr_q, o_addr_d;

  logic       freeze;
  logic [3:0] n_ap_eff;

  assign freeze = bus.stall && (state_q != IDLE);

  always_comb begin
    n_ap_eff = bus.cfg_n_ap;
    if (bus.cfg_n_ap == 4'd0)
      n_ap_eff = 4'd1;
    else if (bus.cfg_n_ap > 4'd8)
      n_ap_eff = 4'd8;
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    b_d        = b_q;
    idx_d      = idx_q;
    tap_d      = tap_q;
    n_ap_d     = n_ap_q;
    nb_act_d   = nb_act_q;
    act_base_d = act_base_q;
    w_base_d   = w_base_q;
    obf_base_d = obf_base_q;
    if (!freeze) begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            n_ap_d     = n_ap_eff;
            nb_act_d   = bus.cfg_nb_act;
            act_base_d = bus.cfg_act_base;
            w_base_d   = bus.cfg_w_base;
            obf_base_d = bus.cfg_obf_base;
            k_d        = '0;
            b_d        = '0;
            idx_d      = '0;
            tap_d      = '0;
            state_d    = WLOAD;
          end
        end
        WLOAD: begin
          if (k_q == KW'(nb_taps)) begin
            idx_d   = '0;
            tap_d   = '0;
            state_d = (nb_act_q == '0) ? DONE : ACT_RD;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        ACT_RD: begin
          b_d     = '0;
          state_d = COMPUTE;
        end
        COMPUTE: begin
          if (b_q == 3'(n_ap_q - 4'd1))
            state_d = WB;
          else
            b_d = b_q + 3'd1;
        end
        WB: begin
          idx_d = idx_q + AW'(1);
          // Modulo counter instead of a divider on idx
          if (tap_q == TW'(nb_taps - 1))
            tap_d = '0;
          else
            tap_d = tap_q + TW'(1);
          if (idx_q + AW'(1) == nb_act_q)
            state_d = DONE;
          else
            state_d = ACT_RD;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE) && !freeze;
    w_ren_d   = 1'b0;
    w_addr_d  = w_addr_q;
    wl_en_d   = '0;
    a_ren_d   = 1'b0;
    a_addr_d  = a_addr_q;
    sel_d     = sel_q;
    dff_en_d  = 1'b0;
    first_d   = 1'b0;
    tap_out_d = '0;
    oreg_d    = 1'b0;
    o_wen_d   = 1'b0;
    o_addr_d  = o_addr_q;
    if (freeze) begin
      tap_out_d = tap_out_q;
    end else begin
      unique case (state_d)
        WLOAD: begin
          if (k_d < KW'(nb_taps)) begin
            w_ren_d  = 1'b1;
            w_addr_d = w_base_d + WW'(k_d);
          end
          // Tap k-1 latches the word read one cycle earlier
          if (k_d != '0)
            wl_en_d = NB'(1) << (k_d - KW'(1));
        end
        ACT_RD: begin
          a_ren_d   = 1'b1;
          a_addr_d  = act_base_d + idx_d;
          tap_out_d = tap_d;
        end
        COMPUTE: begin
          sel_d     = b_d;
          dff_en_d  = 1'b1;
          first_d   = (b_d == 3'd0);
          tap_out_d = tap_d;
        end
        WB: begin
          oreg_d    = 1'b1;
          o_wen_d   = 1'b1;
          o_addr_d  = obf_base_d + OW'(idx_d);
          tap_out_d = tap_d;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      tap_q      <= '0;
      n_ap_q     <= '0;
      nb_act_q   <= '0;
      act_base_q <= '0;
      w_base_q   <= '0;
      obf_base_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      w_ren_q    <= 1'b0;
      w_addr_q   <= '0;
      wl_en_q    <= '0;
      a_ren_q    <= 1'b0;
      a_addr_q   <= '0;
      sel_q      <= '0;
      dff_en_q   <= 1'b0;
      first_q    <= 1'b0;
      tap_out_q  <= '0;
      oreg_q     <= 1'b0;
      o_wen_q    <= 1'b0;
      o_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      b_q        <= b_d;
      idx_q      <= idx_d;
      tap_q      <= tap_d;
      n_ap_q     <= n_ap_d;
      nb_act_q   <= nb_act_d;
      act_base_q <= act_base_d;
      w_base_q   <= w_base_d;
      obf_base_q <= obf_base_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      w_ren_q    <= w_ren_d;
      w_addr_q   <= w_addr_d;
      wl_en_q    <= wl_en_d;
      a_ren_q    <= a_ren_d;
      a_addr_q   <= a_addr_d;
      sel_q      <= sel_d;
      dff_en_q   <= dff_en_d;
      first_q    <= first_d;
      tap_out_q  <= tap_out_d;
      oreg_q     <= oreg_d;
      o_wen_q    <= o_wen_d;
      o_addr_q   <= o_addr_d;
    end
  end

  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.weight_buff_rEn   = w_ren_q;
  assign bus.weight_buff_rAddr = w_addr_q;
  assign bus.weight_load_en    = wl_en_q;
  assign bus.act_buff_rEn      = a_ren_q;
  assign bus.act_buff_rAddr    = a_addr_q;
  assign bus.PAMAC_BPEB_sel    = sel_q;
  assign bus.PAMAC_DFF_en      = dff_en_q;
  assign bus.PAMAC_first_cycle = first_q;
  assign bus.current_tap       = tap_out_q;
  assign bus.out_reg_en        = oreg_q;
  assign bus.obf_wEn           = o_wen_q;
  assign bus.obf_wAddr         = o_addr_q;

endmodule

// File: tb/tb_pe_array_tile_sequencer.sv
// Directed bench for the tile sequencer with a strobe scoreboard.
// Expected strobes are queued at launch and popped as the DUT emits them.
module tb_pe_array_tile_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_array_tile_sequencer_if bus ();

  pe_array_tile_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int exp_busy = 0;
  int exp_wa[$];
  int exp_wl[$];
  int exp_aa[$];
  int exp_sel[$];
  int exp_oa[$];
  int exp_tap[$];

  logic [63:0] outs;
  assign outs = {bus.busy, bus.done, bus.weight_buff_rEn,
                 bus.weight_buff_rAddr, bus.weight_load_en,
                 bus.act_buff_rEn, bus.act_buff_rAddr,
                 bus.PAMAC_BPEB_sel, bus.PAMAC_DFF_en,
                 bus.PAMAC_first_cycle, bus.current_tap,
                 bus.out_reg_en, bus.obf_wEn, bus.obf_wAddr};

  logic [7:0] strobes;
  assign strobes = {bus.weight_buff_rEn, |bus.weight_load_en,
                    bus.act_buff_rEn, bus.PAMAC_DFF_en,
                    bus.PAMAC_first_cycle, bus.out_reg_en,
                    bus.obf_wEn, bus.done};

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (bus.weight_buff_rEn) begin
        chk("w_pending", exp_wa.size() > 0, 1);
        if (exp_wa.size() > 0)
          chk("w_addr", bus.weight_buff_rAddr, exp_wa.pop_front());
      end
      if (bus.weight_load_en != '0) begin
        chk("wl_pending", exp_wl.size() > 0, 1);
        if (exp_wl.size() > 0)
          chk("wl_en", bus.weight_load_en, exp_wl.pop_front());
      end
      if (bus.act_buff_rEn) begin
        chk("a_pending", exp_aa.size() > 0, 1);
        if (exp_aa.size() > 0)
          chk("a_addr", bus.act_buff_rAddr, exp_aa.pop_front());
      end
      if (bus.PAMAC_DFF_en) begin
        chk("sel_pending", exp_sel.size() > 0, 1);
        if (exp_sel.size() > 0)
          chk("sel_first",
              {bus.PAMAC_first_cycle, bus.PAMAC_BPEB_sel},
              exp_sel.pop_front());
      end else begin
        chk("first_wo_en", bus.PAMAC_first_cycle, 0);
      end
      if (bus.obf_wEn) begin
        chk("o_pending", exp_oa.size() > 0, 1);
        chk("oreg_en", bus.out_reg_en, 1);
        if (exp_oa.size() > 0)
          chk("o_addr", bus.obf_wAddr, exp_oa.pop_front());
        if (exp_tap.size() > 0)
          chk("tap", bus.current_tap, exp_tap.pop_front());
      end
    end
  end

  task automatic launch(int n, int na, int ab, int wb, int ob,
                        int extra);
    int e;
    e = (n == 0) ? 1 : ((n > 8) ? 8 : n);
    for (int k = 0; k < 11; k++) begin
      exp_wa.push_back((wb + k) % 128);
      exp_wl.push_back(1 << k);
    end
    for (int i = 0; i < na; i++) begin
      exp_aa.push_back((ab + i) % 1024);
      for (int b = 0; b < e; b++)
        exp_sel.push_back(((b == 0) ? 8 : 0) | b);
      exp_oa.push_back((ob + i) % 8192);
      exp_tap.push_back(i % 11);
    end
    exp_busy = 12 + na * (e + 2) + 1 + extra;
    busy_cnt = 0;
    done_cnt = 0;
    bus.cfg_n_ap     = 4'(n);
    bus.cfg_nb_act   = 10'(na);
    bus.cfg_act_base = 10'(ab);
    bus.cfg_w_base   = 7'(wb);
    bus.cfg_obf_base = 13'(ob);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic finish_tile(string tag);
    int t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_seen"}, done_cnt > 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_idle"}, bus.busy, 0);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_left"}, exp_wa.size() + exp_wl.size()
        + exp_aa.size() + exp_sel.size() + exp_oa.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [12:0] hold_oa;
    logic [3:0]  hold_tap;
    int t;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.cfg_n_ap = '0;
    bus.cfg_nb_act = '0;
    bus.cfg_act_base = '0;
    bus.cfg_w_base = '0;
    bus.cfg_obf_base = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs, 0);
    rst = 1'b0;
    @(negedge clk);

    launch(4, 3, 0, 0, 0, 0);
    finish_tile("basic");

    launch(0, 0, 3, 5, 9, 0);
    finish_tile("nap0_empty");
    launch(12, 0, 3, 5, 9, 0);
    finish_tile("nap12_empty");
    launch(12, 1, 4, 2, 6, 0);
    finish_tile("nap12_one");
    launch(0, 1, 4, 2, 6, 0);
    finish_tile("nap0_one");

    launch(1, 13, 0, 0, 40, 0);
    finish_tile("tap_wrap");

    launch(2, 2, 1023, 120, 8191, 0);
    finish_tile("addr_wrap");

    launch(4, 3, 0, 0, 0, 5);
    t = 0;
    while (!(bus.PAMAC_DFF_en && bus.PAMAC_BPEB_sel == 3'd1)
           && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stall_c_found", bus.PAMAC_DFF_en, 1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_c_strobes", strobes, 0);
      chk("stall_c_sel", bus.PAMAC_BPEB_sel, 1);
      chk("stall_c_busy", bus.busy, 1);
    end
    bus.stall = 1'b0;
    t = 0;
    while (!bus.obf_wEn && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stall_wb_found", bus.obf_wEn, 1);
    hold_oa = bus.obf_wAddr;
    hold_tap = bus.current_tap;
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_wb_strobes", strobes, 0);
      chk("stall_wb_addr", bus.obf_wAddr, hold_oa);
      chk("stall_wb_tap", bus.current_tap, hold_tap);
    end
    bus.stall = 1'b0;
    finish_tile("stall");

    launch(4, 2, 0, 10, 0, 0);
    t = 0;
    while (!(bus.weight_buff_rEn && bus.weight_buff_rAddr == 7'd15)
           && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_k5_found", bus.weight_buff_rAddr, 15);
    rst = 1'b1;
    #1;
    chk("rst_async_outs", outs, 0);
    exp_wa.delete();
    exp_wl.delete();
    exp_aa.delete();
    exp_sel.delete();
    exp_oa.delete();
    exp_tap.delete();
    @(negedge clk);
    chk("rst_hold_outs", outs, 0);
    @(negedge clk);
    chk("rst_no_done", done_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    launch(4, 2, 7, 10, 20, 0);
    finish_tile("after_rst");

    launch(3, 3, 5, 3, 100, 0);
    t = 0;
    while (!bus.PAMAC_DFF_en && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("busy_start_found", bus.PAMAC_DFF_en, 1);
    bus.cfg_nb_act = 10'd9;
    bus.cfg_n_ap = 4'd1;
    bus.cfg_act_base = 10'd0;
    bus.cfg_obf_base = 13'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    finish_tile("start_busy");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
